i2c_bus_conditioner: RTL and testbench
======================================

// Module: i2c_bus_conditioner
// PURPOSE
//  Input front end for the I2C BERT core. Takes raw SCL/SDA pad inputs from the
//  TT top wrapper (ui_in/uio_in bits), synchronises and glitch-filters them.
//  Emits single-cycle bus events: SCL edges, START, STOP, sampled bit.
//  Tracks bus-busy state with an idle timeout. All downstream I2C logic consumes
//  only these outputs, never raw pins.
// PARAMETERS
//  SYNC_STAGES   2    flops in each input synchroniser (min 2)
//  FILTER_LEN    3    consecutive equal samples needed before a filtered line changes (1..15)
//  TIMEOUT_W     12   width of idle-timeout counter
//  TIMEOUT_MAX   4095 cycles of SCL=1,SDA=1 while BUSY before forced IDLE
// PORTS
//  clk          in   1  core clock
//  rst_n        in   1  asynchronous active-low reset
//  ena          in   1  block enable; low = hold idle
//  scl_raw      in   1  unsynchronised SCL pad input
//  sda_raw      in   1  unsynchronised SDA pad input
//  scl          out  1  filtered SCL level
//  sda          out  1  filtered SDA level
//  scl_rise     out  1  1-cycle pulse, filtered SCL 0->1
//  scl_fall     out  1  1-cycle pulse, filtered SCL 1->0
//  start        out  1  1-cycle pulse, START or repeated START detected
//  stop         out  1  1-cycle pulse, STOP detected
//  bit_valid    out  1  1-cycle pulse coincident with scl_rise
//  bit_data     out  1  filtered SDA at scl_rise (held until next bit_valid)
//  bus_busy     out  1  1 between START and STOP/timeout
//  timeout      out  1  1-cycle pulse when idle timeout forces IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values: scl=1, sda=1, bus_busy=0, bit_data=0; all pulses 0; sync flops=1;
//   filter counters=0; timeout counter=0.
//  Sync: SYNC_STAGES flop chain per line.
//  Filter: per line, a counter increments while sync output != filtered level.
//   It clears when they are equal. On reaching FILTER_LEN-1 with mismatch still present,
//   filtered level flips and counter clears.
//  Latency: raw edge to filtered edge = SYNC_STAGES+FILTER_LEN cycles (2+3 -> 5).
//   A glitch shorter than FILTER_LEN samples is never seen.
//  Edges: scl_rise/scl_fall are registered compares of filtered scl vs its previous
//   value; they fire in the cycle after the filtered change.
//  START: filtered sda 1->0 while filtered scl is 1 in both previous and current cycle.
//   STOP is the same with sda 0->1.
//   If scl and sda change in the same cycle, neither START nor STOP fires.
//  bit_valid fires with scl_rise; bit_data captures filtered sda at that edge.
//   Bits during START/STOP SCL-high phases are still reported; the core discards them.
//  FSM {IDLE, BUSY}:
//   IDLE -start-> BUSY.
//   BUSY -start-> BUSY (repeated START, counter cleared).
//   BUSY -stop-> IDLE.
//   BUSY -timeout-> IDLE.
//   stop in IDLE: pulse stop, stay IDLE.
//  Timeout: in BUSY, counter increments while scl=1 && sda=1 and clears otherwise.
//   At TIMEOUT_MAX it pulses timeout and goes to IDLE; the counter saturates and never wraps.
//  ena=0, synchronous: filtered lines forced to 1, counters cleared, FSM to IDLE,
//   all pulses suppressed. Sync flops keep running.
//   On ena 0->1, no spurious events; a line held low shows its fall after FILTER_LEN cycles.
//  Reset mid-transaction: immediate return to reset values. A START is not inferred from
//   lines that were already low when reset released (filtered starts at 1, so a falling
//   scl edge fires scl_fall only).
// STRUCTURE
//  Package i2c_bert_pkg:
//   typedef enum logic [0:0] {BUS_IDLE, BUS_BUSY} bus_state_t;
//   localparams for default FILTER_LEN and TIMEOUT_MAX.
//  Sub-module i2c_line_filter (sync chain + glitch counter, one per line),
//   instantiated twice; edge/START/STOP/FSM logic stays in this module.
// TESTING
//  1. Reset, ena=1, lines high 20 cycles -> scl=sda=1, no pulses, bus_busy=0.
//  2. sda_raw 1->0 at t, scl_raw=1 -> sda falls t+5, start pulse t+6, bus_busy=1 from t+7.
//  3. 2-cycle low glitch on scl_raw while busy -> scl stays 1, no scl_fall or bit_valid.
//  4. 8 SCL clocks with SDA=0xA5 MSB-first, then STOP -> 8 bit_valid, bits 1,0,1,0,0,1,0,1;
//     stop pulse; bus_busy=0.
//  5. START, then lines held high 4095 cycles -> timeout pulse once, bus_busy=0, no stop pulse.
//  6. scl_raw and sda_raw fall same cycle -> scl_fall only, no start. Then ena=0 mid-BUSY ->
//     bus_busy=0 next cycle, scl=sda=1.

Source files
------------

// File: rtl/i2c_bus_conditioner_pkg.sv
// Shared types and default constants for the I2C BERT input front end.
package i2c_bert_pkg;

  typedef enum logic [0:0] {
    BUS_IDLE,
    BUS_BUSY
  } bus_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_FILTER_LEN  = 3;
  localparam int DEFAULT_TIMEOUT_W   = 12;
  localparam int DEFAULT_TIMEOUT_MAX = 4095;

  // True when both filtered lines sit released (high), i.e. the bus looks idle.
  function automatic logic lines_released(input logic scl_level, input logic sda_level);
    return scl_level & sda_level;
  endfunction

endpackage

// File: rtl/i2c_bus_conditioner_line_filter.sv
// One I2C line: metastability synchroniser followed by a glitch filter that
// only lets the filtered level change after FILTER_LEN agreeing samples.
module i2c_line_filter
  import i2c_bert_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_LEN  = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic level
);

  localparam logic [3:0] LAST_COUNT = 4'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [3:0]             count;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; keeps running even while the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Glitch filter: count consecutive disagreeing samples, flip after FILTER_LEN of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
      level <= 1'b1;
    end else if (!ena) begin
      count <= 4'd0;
      level <= 1'b1;
    end else if (sync_out != level) begin
      if (count == LAST_COUNT) begin
        level <= ~level;
        count <= 4'd0;
      end else begin
        count <= count + 4'd1;
      end
    end else begin
      count <= 4'd0;
    end
  end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C bus front end: filtered SCL/SDA levels, single-cycle bus events
// (SCL edges, START, STOP, sampled bit) and bus-busy tracking with idle timeout.
module i2c_bus_conditioner
  import i2c_bert_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_LEN  = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_W   = DEFAULT_TIMEOUT_W,
  parameter int TIMEOUT_MAX = DEFAULT_TIMEOUT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic bit_valid,
  output logic bit_data,
  output logic bus_busy,
  output logic timeout
);

  localparam logic [TIMEOUT_W-1:0] COUNT_MAX = TIMEOUT_W'(TIMEOUT_MAX);

  bus_state_t           state;
  bus_state_t           state_next;
  logic                 scl_prev;
  logic                 sda_prev;
  logic                 scl_rising;
  logic [TIMEOUT_W-1:0] idle_count;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .raw   (scl_raw),
    .level (scl)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .raw   (sda_raw),
    .level (sda)
  );

  assign scl_rising = scl & ~scl_prev;
  assign bus_busy   = (state == BUS_BUSY);

  // Registered event detection against the previous filtered levels; a
  // simultaneous SCL/SDA change fails the "SCL high both cycles" test, so no START/STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
    end else if (!ena) begin
      scl_prev  <= 1'b1;
      sda_prev  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      scl_prev  <= scl;
      sda_prev  <= sda;
      scl_rise  <= scl_rising;
      scl_fall  <= ~scl & scl_prev;
      bit_valid <= scl_rising;
      start     <= scl_prev & scl & sda_prev & ~sda;
      stop      <= scl_prev & scl & ~sda_prev & sda;
      if (scl_rising) begin
        bit_data <= sda;
      end
    end
  end

  // Bus state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BUS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next bus state and the timeout pulse; disable forces IDLE silently.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    case (state)
      BUS_IDLE: begin
        if (start) begin
          state_next = BUS_BUSY;
        end
      end
      BUS_BUSY: begin
        if (start) begin
          state_next = BUS_BUSY;
        end else if (stop) begin
          state_next = BUS_IDLE;
        end else if (idle_count == COUNT_MAX) begin
          timeout    = 1'b1;
          state_next = BUS_IDLE;
        end
      end
      default: begin
        state_next = BUS_IDLE;
      end
    endcase
    if (!ena) begin
      state_next = BUS_IDLE;
      timeout    = 1'b0;
    end
  end

  // Idle-timeout counter: counts released-bus cycles while BUSY, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_count <= '0;
    end else if (!ena || (state != BUS_BUSY) || start || stop || timeout) begin
      idle_count <= '0;
    end else if (lines_released(scl, sda)) begin
      if (idle_count != COUNT_MAX) begin
        idle_count <= idle_count + 1'b1;
      end
    end else begin
      idle_count <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Self-checking bench for i2c_bus_conditioner: directed bus scenarios plus
// randomized line activity, all checked cycle by cycle against a behavioural model.
module tb_i2c_bus_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
  localparam int TIMEOUT_W   = 12;
  localparam int TIMEOUT_MAX = 4095;

  logic clk = 1'b0;
  logic rst_n, ena, scl_raw, sda_raw;
  logic scl, sda, scl_rise, scl_fall, start, stop;
  logic bit_valid, bit_data, bus_busy, timeout;

  i2c_bus_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_MAX (TIMEOUT_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .scl_raw   (scl_raw),
    .sda_raw   (sda_raw),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start     (start),
    .stop      (stop),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bus_busy  (bus_busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Behavioural model state: line 0 is SCL, line 1 is SDA.
  logic m_pipe[2][SYNC_STAGES];
  int   m_run[2];
  logic m_filt[2];
  logic m_prev[2];
  logic m_rise, m_fall, m_start, m_stop, m_bit_valid, m_bit_data, m_busy;
  int   m_idle;

  // Observation counters for directed scenarios.
  int n_rise, n_fall, n_start, n_stop, n_bits, n_tmo;
  int sda_low_cyc, scl_low_cyc, start_cyc, busy_cyc;
  logic bits_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SYNC_STAGES; k++) m_pipe[i][k] = 1'b1;
      m_run[i]  = 0;
      m_filt[i] = 1'b1;
      m_prev[i] = 1'b1;
    end
    m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0;
    m_bit_valid = 0; m_bit_data = 0; m_busy = 0; m_idle = 0;
  endtask

  // One clock edge of the specified behaviour, from the values visible just before the edge.
  task automatic modelEdge(input logic e, input logic rs, input logic rd);
    logic raw[2];
    logic sync_out[2];
    logic f[2];
    logic p[2];
    logic st, sp, busy_old, tmo_old;
    int   idle_old;
    raw[0] = rs;
    raw[1] = rd;
    for (int i = 0; i < 2; i++) begin
      sync_out[i] = m_pipe[i][SYNC_STAGES-1];
      for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
      m_pipe[i][0] = raw[i];
      f[i] = m_filt[i];
      p[i] = m_prev[i];
    end
    st = m_start;
    sp = m_stop;
    busy_old = m_busy;
    idle_old = m_idle;
    tmo_old  = busy_old && (idle_old == TIMEOUT_MAX);
    if (!e) begin
      for (int i = 0; i < 2; i++) begin
        m_filt[i] = 1'b1;
        m_run[i]  = 0;
        m_prev[i] = 1'b1;
      end
      m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_bit_valid = 0;
      m_busy = 0; m_idle = 0;
    end else begin
      m_rise      = !p[0] && f[0];
      m_fall      = p[0] && !f[0];
      m_bit_valid = m_rise;
      if (m_rise) m_bit_data = f[1];
      m_start = p[0] && f[0] && p[1] && !f[1];
      m_stop  = p[0] && f[0] && !p[1] && f[1];
      for (int i = 0; i < 2; i++) begin
        m_prev[i] = f[i];
        if (sync_out[i] !== f[i]) begin
          m_run[i]++;
          if (m_run[i] == FILTER_LEN) begin
            m_filt[i] = ~f[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (!busy_old) begin
        m_busy = st;
        m_idle = 0;
      end else if (st) begin
        m_idle = 0;
      end else if (sp || tmo_old) begin
        m_busy = 0;
        m_idle = 0;
      end else if (f[0] && f[1]) begin
        m_idle = (idle_old < TIMEOUT_MAX) ? idle_old + 1 : idle_old;
      end else begin
        m_idle = 0;
      end
    end
  endtask

  function automatic logic [9:0] dutVec();
    return {scl, sda, scl_rise, scl_fall, start, stop, bit_valid, bit_data, bus_busy, timeout};
  endfunction

  function automatic logic [9:0] modelVec();
    logic tmo;
    tmo = ena && m_busy && (m_idle == TIMEOUT_MAX);
    return {m_filt[0], m_filt[1], m_rise, m_fall, m_start, m_stop,
            m_bit_valid, m_bit_data, m_busy, tmo};
  endfunction

  task automatic clearObs();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_bits = 0; n_tmo = 0;
    sda_low_cyc = -1; scl_low_cyc = -1; start_cyc = -1; busy_cyc = -1;
    bits_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelEdge(ena, scl_raw, sda_raw);
    cyc++;
    #1;
    checkOutput("cycle", 32'(dutVec()), 32'(modelVec()));
    if (scl_rise) n_rise++;
    if (scl_fall) n_fall++;
    if (start) begin
      n_start++;
      if (start_cyc < 0) start_cyc = cyc;
    end
    if (stop) n_stop++;
    if (bit_valid) begin
      n_bits++;
      bits_q.push_back(bit_data);
    end
    if (timeout) n_tmo++;
    if (!sda && sda_low_cyc < 0) sda_low_cyc = cyc;
    if (!scl && scl_low_cyc < 0) scl_low_cyc = cyc;
    if (bus_busy && busy_cyc < 0) busy_cyc = cyc;
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic e, input int n);
    scl_raw = s;
    sda_raw = d;
    ena     = e;
    repeat (n) tick();
  endtask

  task automatic doReset(input logic s, input logic d);
    scl_raw = s;
    sda_raw = d;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_vals", 32'(dutVec()), 32'(10'b11_0000_0000));
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    logic [7:0] data;
    logic [7:0] got_byte;
    rst_n = 1'b1;
    ena = 1'b1;
    scl_raw = 1'b1;
    sda_raw = 1'b1;
    modelReset();
    clearObs();

    doReset(1'b1, 1'b1);

    // Idle bus stays quiet.
    clearObs();
    applyStimulus(1, 1, 1, 20);
    checkOutput("idle_pulses", n_rise + n_fall + n_start + n_stop + n_bits + n_tmo, 0);
    checkOutput("idle_levels", {29'd0, scl, sda, bus_busy}, 32'b110);

    // START latency.
    clearObs();
    t = cyc;
    applyStimulus(1, 0, 1, 12);
    checkOutput("sda_fall_lat", sda_low_cyc - t, 5);
    checkOutput("start_lat", start_cyc - t, 6);
    checkOutput("busy_lat", busy_cyc - t, 7);
    checkOutput("start_count", n_start, 1);

    // Short SCL glitch is swallowed.
    clearObs();
    applyStimulus(0, 0, 1, 2);
    applyStimulus(1, 0, 1, 12);
    checkOutput("glitch_scl_low", scl_low_cyc, -1);
    checkOutput("glitch_fall", n_fall, 0);
    checkOutput("glitch_bits", n_bits, 0);
    checkOutput("glitch_busy", bus_busy, 1);

    // Byte 0xA5 MSB first, then STOP.
    data = 8'hA5;
    clearObs();
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(0, sda_raw, 1, 8);
      applyStimulus(0, data[i], 1, 8);
      applyStimulus(1, data[i], 1, 8);
    end
    got_byte = 8'h00;
    foreach (bits_q[i]) got_byte = {got_byte[6:0], bits_q[i]};
    checkOutput("byte_bits", n_bits, 8);
    checkOutput("byte_value", got_byte, 8'hA5);
    checkOutput("byte_no_ss", n_start + n_stop, 0);
    clearObs();
    applyStimulus(0, 0, 1, 8);
    applyStimulus(1, 0, 1, 8);
    applyStimulus(1, 1, 1, 12);
    checkOutput("stop_count", n_stop, 1);
    checkOutput("stop_busy", bus_busy, 0);

    // Idle timeout after START.
    clearObs();
    applyStimulus(1, 0, 1, 12);
    checkOutput("tmo_busy", bus_busy, 1);
    applyStimulus(0, 0, 1, 8);
    applyStimulus(0, 1, 1, 8);
    applyStimulus(1, 1, 1, 4200);
    checkOutput("tmo_count", n_tmo, 1);
    checkOutput("tmo_no_stop", n_stop, 0);
    checkOutput("tmo_busy_after", bus_busy, 0);

    // Simultaneous fall: edge only, no START.
    clearObs();
    applyStimulus(0, 0, 1, 15);
    checkOutput("same_fall", n_fall, 1);
    checkOutput("same_no_start", n_start, 0);
    applyStimulus(1, 1, 1, 12);
    applyStimulus(1, 0, 1, 12);
    checkOutput("pre_dis_busy", bus_busy, 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("dis_levels", {29'd0, scl, sda, bus_busy}, 32'b110);

    // Re-enable with lines low: fall after FILTER_LEN cycles.
    applyStimulus(0, 0, 0, 6);
    clearObs();
    t = cyc;
    applyStimulus(0, 0, 1, 8);
    checkOutput("reena_lat", scl_low_cyc - t, FILTER_LEN);
    checkOutput("reena_fall", n_fall, 1);
    checkOutput("reena_no_start", n_start, 0);

    // Re-enable with lines high: nothing at all.
    applyStimulus(1, 1, 0, 4);
    clearObs();
    applyStimulus(1, 1, 1, 10);
    checkOutput("reena_quiet", n_rise + n_fall + n_start + n_stop + n_bits + n_tmo, 0);

    // Reset mid-transaction with lines already low.
    applyStimulus(1, 0, 1, 12);
    checkOutput("pre_rst_busy", bus_busy, 1);
    doReset(0, 0);
    clearObs();
    applyStimulus(0, 0, 1, 12);
    checkOutput("rst_fall", n_fall, 1);
    checkOutput("rst_no_start", n_start, 0);
    checkOutput("rst_busy", bus_busy, 0);

    // Randomized line activity including glitches and enable drops.
    applyStimulus(1, 1, 1, 10);
    for (int seg = 0; seg < 400; seg++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) != 0), $urandom_range(1, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
